// File: rtl/regfile_mp_scoreboard_if.sv
// Register-file port bundle: write ports, read ports, issue port and scoreboard view.
interface regfile_mp_scoreboard_if #(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned RegAddress = 5,
  parameter int unsigned NumRegs    = 32,
  parameter int unsigned NumRead    = 2,
  parameter int unsigned NumWrite   = 2
);
  logic [NumWrite-1:0]            we;
  logic [NumWrite*RegAddress-1:0] waddr;
  logic [NumWrite*DataWidth-1:0]  wdata;
  logic [NumRead*RegAddress-1:0]  raddr;
  logic [NumRead*DataWidth-1:0]   rdata;
  logic [NumRead-1:0]             rbusy;
  logic                           issue_valid;
  logic [RegAddress-1:0]          issue_rd;
  logic [NumRegs-1:0]             busy;

  modport master (
    output we, waddr, wdata, raddr, issue_valid, issue_rd,
    input  rdata, rbusy, busy
  );

  modport slave (
    input  we, waddr, wdata, raddr, issue_valid, issue_rd,
    output rdata, rbusy, busy
  );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port flop register file with optional zero register, write-to-read bypass
// and a per-register busy scoreboard (set at issue, cleared at writeback).
module regfile_mp_scoreboard #(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned RegAddress = 5,
  parameter int unsigned NumRegs    = 32,
  parameter int unsigned NumRead    = 2,
  parameter int unsigned NumWrite   = 2,
  parameter bit          ZeroReg    = 1'b1,
  parameter bit          Bypass     = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  regfile_mp_scoreboard_if.slave bus
);

  logic [DataWidth-1:0]   regs   [NumRegs];
  logic [DataWidth-1:0]   wr_val [NumRegs];
  logic [NumRegs-1:0]     wr_hit;
  logic [NumRegs-1:0]     set_vec;
  logic [NumRegs-1:0]     busy_q;
  logic [NumRegs-1:0]     busy_d;
  logic [RegAddress-1:0]  wa     [NumWrite];
  logic [DataWidth-1:0]   wd     [NumWrite];
  logic [NumWrite-1:0]    wr_ok;
  logic [RegAddress-1:0]  ra     [NumRead];
  logic [NumRead*DataWidth-1:0] rdata_c;
  logic [NumRead-1:0]     rbusy_c;
  logic                   issue_ok;

  // An address names a real, writable register (in range and not the hardwired zero).
  function automatic logic addr_ok(input logic [RegAddress-1:0] a);
    return (32'(a) < NumRegs) && !(ZeroReg && (a == '0));
  endfunction

  // Unpack write ports and qualify them.
  always_comb begin
    for (int i = 0; i < NumWrite; i++) begin
      wa[i]    = bus.waddr[i*RegAddress +: RegAddress];
      wd[i]    = bus.wdata[i*DataWidth +: DataWidth];
      wr_ok[i] = bus.we[i] && addr_ok(wa[i]);
    end
  end

  // Per-register write decode; later ports overwrite earlier ones so the highest index wins.
  always_comb begin
    wr_hit = '0;
    for (int k = 0; k < NumRegs; k++) wr_val[k] = '0;
    for (int i = 0; i < NumWrite; i++) begin
      for (int k = 0; k < NumRegs; k++) begin
        if (wr_ok[i] && (wa[i] == RegAddress'(k))) begin
          wr_hit[k] = 1'b1;
          wr_val[k] = wd[i];
        end
      end
    end
  end

  assign issue_ok = bus.issue_valid && addr_ok(bus.issue_rd);

  // Set after clear: a fresh issue outranks a writeback from the older producer.
  always_comb begin
    set_vec = '0;
    for (int k = 0; k < NumRegs; k++) begin
      set_vec[k] = issue_ok && (bus.issue_rd == RegAddress'(k));
    end
    busy_d = (busy_q & ~wr_hit) | set_vec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      for (int k = 0; k < NumRegs; k++) regs[k] <= '0;
    end else begin
      busy_q <= busy_d;
      for (int k = 0; k < NumRegs; k++) begin
        if (wr_hit[k]) regs[k] <= wr_val[k];
      end
    end
  end

  // Combinational read; a bypassed hit also reports not-busy to match the forwarded data.
  always_comb begin
    rdata_c = '0;
    rbusy_c = '0;
    for (int j = 0; j < NumRead; j++) begin
      ra[j] = bus.raddr[j*RegAddress +: RegAddress];
      if (addr_ok(ra[j])) begin
        for (int k = 0; k < NumRegs; k++) begin
          if (ra[j] == RegAddress'(k)) begin
            if (Bypass && wr_hit[k]) begin
              rdata_c[j*DataWidth +: DataWidth] = wr_val[k];
              rbusy_c[j]                        = 1'b0;
            end else begin
              rdata_c[j*DataWidth +: DataWidth] = regs[k];
              rbusy_c[j]                        = busy_q[k];
            end
          end
        end
      end
    end
  end

  assign bus.rdata = rdata_c;
  assign bus.rbusy = rbusy_c;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Scoreboard bench: one bypassing and one non-bypassing register file driven in lockstep
// and compared against a behavioural array model.
module tb_regfile_mp_scoreboard;
  localparam int unsigned DW    = 32;
  localparam int unsigned RA    = 5;
  localparam int unsigned NREGS = 24;
  localparam int unsigned NRD   = 2;
  localparam int unsigned NWR   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_scoreboard_if #(.DataWidth(DW), .RegAddress(RA), .NumRegs(NREGS),
                             .NumRead(NRD), .NumWrite(NWR)) bus_b ();
  regfile_mp_scoreboard_if #(.DataWidth(DW), .RegAddress(RA), .NumRegs(NREGS),
                             .NumRead(NRD), .NumWrite(NWR)) bus_n ();

  regfile_mp_scoreboard #(.DataWidth(DW), .RegAddress(RA), .NumRegs(NREGS), .NumRead(NRD),
                          .NumWrite(NWR), .ZeroReg(1'b1), .Bypass(1'b1))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  regfile_mp_scoreboard #(.DataWidth(DW), .RegAddress(RA), .NumRegs(NREGS), .NumRead(NRD),
                          .NumWrite(NWR), .ZeroReg(1'b1), .Bypass(1'b0))
    dut_n (.clk(clk), .rst(rst), .bus(bus_n.slave));

  typedef struct {
    logic [NRD*DW-1:0] rdata_b;
    logic [NRD*DW-1:0] rdata_n;
    logic [NRD-1:0]    rbusy_b;
    logic [NRD-1:0]    rbusy_n;
    logic [NREGS-1:0]  busy;
  } exp_t;

  exp_t exp_q[$];

  logic [DW-1:0] m_regs [NREGS];
  bit            m_busy [NREGS];

  bit            s_rst;
  logic [NWR-1:0] s_we;
  int            s_wa [NWR];
  logic [DW-1:0] s_wd [NWR];
  int            s_ra [NRD];
  bit            s_iv;
  int            s_ird;

  int checks = 0;
  int errors = 0;

  function automatic void model_clear();
    for (int k = 0; k < NREGS; k++) begin
      m_regs[k] = '0;
      m_busy[k] = 1'b0;
    end
  endfunction

  // Architectural read: x0 and out-of-range read 0/idle; bypass takes the last matching write.
  function automatic void model_read(input bit byp, input int a,
                                     output logic [DW-1:0] d, output bit b);
    d = '0;
    b = 1'b0;
    if (a != 0 && a < int'(NREGS)) begin
      d = m_regs[a];
      b = m_busy[a];
      if (byp) begin
        for (int i = 0; i < int'(NWR); i++) begin
          if (s_we[i] && s_wa[i] == a) begin
            d = s_wd[i];
            b = 1'b0;
          end
        end
      end
    end
  endfunction

  function automatic void model_commit();
    for (int i = 0; i < int'(NWR); i++) begin
      if (s_we[i] && s_wa[i] != 0 && s_wa[i] < int'(NREGS)) begin
        m_regs[s_wa[i]] = s_wd[i];
        m_busy[s_wa[i]] = 1'b0;
      end
    end
    if (s_iv && s_ird != 0 && s_ird < int'(NREGS)) m_busy[s_ird] = 1'b1;
  endfunction

  task automatic idle();
    s_we  = '0;
    s_iv  = 1'b0;
    s_ird = 0;
    for (int i = 0; i < int'(NWR); i++) begin
      s_wa[i] = 0;
      s_wd[i] = '0;
    end
    for (int j = 0; j < int'(NRD); j++) s_ra[j] = 0;
  endtask

  task automatic rand_stim();
    s_we  = NWR'($urandom_range(0, 3));
    s_iv  = ($urandom_range(0, 2) == 0);
    s_ird = int'($urandom_range(0, 31));
    for (int i = 0; i < int'(NWR); i++) begin
      s_wa[i] = int'($urandom_range(0, 31));
      s_wd[i] = $urandom;
    end
    for (int j = 0; j < int'(NRD); j++) s_ra[j] = int'($urandom_range(0, 31));
    if ($urandom_range(0, 3) == 0) s_ra[0] = s_wa[$urandom_range(0, 1)];
    if ($urandom_range(0, 3) == 0) s_ird = s_wa[0];
    if ($urandom_range(0, 7) == 0) s_wa[1] = s_wa[0];
  endtask

  // Drive one cycle at the falling edge, queue what the outputs must show before the next rise.
  task automatic step();
    exp_t          e;
    logic [DW-1:0] d;
    bit            b;
    @(negedge clk);
    rst = s_rst;
    if (!s_rst) model_clear();
    bus_b.we = s_we;  bus_n.we = s_we;
    bus_b.issue_valid = s_iv;  bus_n.issue_valid = s_iv;
    bus_b.issue_rd = RA'(s_ird);  bus_n.issue_rd = RA'(s_ird);
    for (int i = 0; i < int'(NWR); i++) begin
      bus_b.waddr[i*RA +: RA] = RA'(s_wa[i]);  bus_n.waddr[i*RA +: RA] = RA'(s_wa[i]);
      bus_b.wdata[i*DW +: DW] = s_wd[i];       bus_n.wdata[i*DW +: DW] = s_wd[i];
    end
    for (int j = 0; j < int'(NRD); j++) begin
      bus_b.raddr[j*RA +: RA] = RA'(s_ra[j]);  bus_n.raddr[j*RA +: RA] = RA'(s_ra[j]);
    end
    e.rdata_b = '0; e.rdata_n = '0; e.rbusy_b = '0; e.rbusy_n = '0; e.busy = '0;
    for (int j = 0; j < int'(NRD); j++) begin
      model_read(1'b1, s_ra[j], d, b);
      e.rdata_b[j*DW +: DW] = d;
      e.rbusy_b[j] = b;
      model_read(1'b0, s_ra[j], d, b);
      e.rdata_n[j*DW +: DW] = d;
      e.rbusy_n[j] = b;
    end
    for (int k = 0; k < int'(NREGS); k++) e.busy[k] = m_busy[k];
    exp_q.push_back(e);
    if (s_rst) model_commit();
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
    end
  endtask

  // Monitor: sample mid-cycle, after the driver has settled inputs and before the next rise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rdata_byp",   64'(bus_b.rdata), 64'(e.rdata_b));
        check("rbusy_byp",   64'(bus_b.rbusy), 64'(e.rbusy_b));
        check("busy_byp",    64'(bus_b.busy),  64'(e.busy));
        check("rdata_nobyp", 64'(bus_n.rdata), 64'(e.rdata_n));
        check("rbusy_nobyp", 64'(bus_n.rbusy), 64'(e.rbusy_n));
        check("busy_nobyp",  64'(bus_n.busy),  64'(e.busy));
      end
    end
  end

  initial begin
    model_clear();
    idle();
    s_rst = 1'b0;
    // Held in reset across clock edges
    step(); step();
    // Release; write to x0 is dropped
    idle(); s_rst = 1'b1; s_we = 2'b01; s_wa[0] = 0; s_wd[0] = 32'hDEADBEEF; step();
    idle(); step();
    // Both ports write x5; port 1 wins
    idle(); s_we = 2'b11; s_wa[0] = 5; s_wd[0] = 32'h11111111;
    s_wa[1] = 5; s_wd[1] = 32'h22222222; s_ra[0] = 5; s_ra[1] = 5; step();
    idle(); s_ra[0] = 5; step();
    // Write x7 while reading it
    idle(); s_we = 2'b01; s_wa[0] = 7; s_wd[0] = 32'hA5A5A5A5; s_ra[1] = 7; step();
    idle(); s_ra[1] = 7; step();
    // Issue x3, hold busy, write it back
    idle(); s_iv = 1'b1; s_ird = 3; s_ra[0] = 3; step();
    repeat (3) begin idle(); s_ra[0] = 3; step(); end
    idle(); s_we = 2'b10; s_wa[1] = 3; s_wd[1] = 32'h00000333; s_ra[0] = 3; step();
    idle(); s_ra[0] = 3; step();
    // Issue and write x9 together; then issue x0
    idle(); s_iv = 1'b1; s_ird = 9; s_we = 2'b01; s_wa[0] = 9; s_wd[0] = 32'h99999999;
    s_ra[0] = 9; step();
    idle(); s_iv = 1'b1; s_ird = 0; s_ra[0] = 9; s_ra[1] = 0; step();
    idle(); s_ra[0] = 9; s_ra[1] = 0; step();
    // Out-of-range write, issue and reads
    idle(); s_we = 2'b01; s_wa[0] = 30; s_wd[0] = 32'hBADC0FFE; s_iv = 1'b1; s_ird = 28;
    s_ra[0] = 30; s_ra[1] = 28; step();
    idle(); s_ra[0] = 30; s_ra[1] = 23; step();
    // Randomized traffic
    repeat (400) begin rand_stim(); step(); end
    // Mid-stream asynchronous reset with x3 busy and x5 nonzero
    idle(); s_iv = 1'b1; s_ird = 3; s_we = 2'b01; s_wa[0] = 5; s_wd[0] = 32'h5A5A0001; step();
    idle(); s_ra[0] = 5; s_ra[1] = 3; step();
    idle(); s_ra[0] = 5; s_ra[1] = 3; s_rst = 1'b0; step();
    idle(); s_ra[0] = 5; s_ra[1] = 3; s_rst = 1'b1; step();
    repeat (60) begin rand_stim(); step(); end

    @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
